// File: rtl/cmplx_alu2_pipe.sv
// rtl/cmplx_alu2_pipe.sv - two-input complex streaming ALU, 3-stage pipeline, split back-pressured outputs
module cmplx_alu2_pipe #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic [2*WIDTH-1:0] i0_tdata,
    input  logic               i0_tlast,
    input  logic               i0_tvalid,
    output logic               i0_tready,
    input  logic [2*WIDTH-1:0] i1_tdata,
    input  logic               i1_tlast,
    input  logic               i1_tvalid,
    output logic               i1_tready,
    output logic [2*WIDTH-1:0] o0_tdata,
    output logic               o0_tlast,
    output logic               o0_tvalid,
    input  logic               o0_tready,
    output logic [2*WIDTH-1:0] o1_tdata,
    output logic               o1_tlast,
    output logic               o1_tvalid,
    input  logic               o1_tready,
    output logic               err_tlast
);
    localparam int DW = 2*WIDTH;
    localparam int PW = 2*WIDTH + 2;
    localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_PASS = 2'd2;

    function automatic logic signed [PW-1:0] ext_p(input logic signed [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] ext_w(input logic signed [WIDTH-1:0] v);
        return {{(PW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] finish_val(input logic signed [PW-1:0] v, input logic mul);
        logic signed [PW-1:0] r;
        r = mul ? ((v + RND) >>> SHIFT) : v;
        if (r > MAXV)
            return MAXV[WIDTH-1:0];
        else if (r < MINV)
            return MINV[WIDTH-1:0];
        return r[WIDTH-1:0];
    endfunction

    // Reset asserts immediately but releases only on a clock edge.
    logic rst_meta, rst_n_s;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_n_s  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n_s  <= rst_meta;
        end
    end

    logic s1_valid, s2_valid, s3_valid;
    logic s1_load, s2_load, s3_load, accept, retire;
    logic done0, done1, ok0, ok1;
    logic sop;
    logic [1:0] mode_q, beat_mode;
    logic [DW-1:0] s1_a, s1_b;
    logic s1_last, s2_last, s2_mul;
    logic [1:0] s1_op;
    logic signed [PW-1:0] s2_p0i, s2_p0q, s2_p1i, s2_p1q;
    logic signed [PW-1:0] p0i, p0q, p1i, p1q;
    logic signed [WIDTH-1:0] ai, aq, bi, bq;
    logic signed [DW-1:0] m_ii, m_qq, m_iq, m_qi;

    assign o0_tvalid = s3_valid & ~done0;
    assign o1_tvalid = s3_valid & ~done1;
    assign ok0       = o0_tvalid & o0_tready;
    assign ok1       = o1_tvalid & o1_tready;
    assign retire    = s3_valid & (done0 | ok0) & (done1 | ok1);
    assign s3_load   = ~s3_valid | retire;
    assign s2_load   = ~s2_valid | s3_load;
    assign s1_load   = ~s1_valid | s2_load;
    assign accept    = i0_tvalid & i1_tvalid & s1_load & rst_n_s;
    assign i0_tready = accept;
    assign i1_tready = accept;
    assign beat_mode = sop ? mode : mode_q;

    assign ai   = s1_a[DW-1:WIDTH];
    assign aq   = s1_a[WIDTH-1:0];
    assign bi   = s1_b[DW-1:WIDTH];
    assign bq   = s1_b[WIDTH-1:0];
    assign m_ii = DW'(ai) * DW'(bi);
    assign m_qq = DW'(aq) * DW'(bq);
    assign m_iq = DW'(ai) * DW'(bq);
    assign m_qi = DW'(aq) * DW'(bi);

    always_comb begin
        p0i = ext_w(ai) + ext_w(bi);
        p0q = ext_w(aq) + ext_w(bq);
        p1i = ext_w(ai) - ext_w(bi);
        p1q = ext_w(aq) - ext_w(bq);
        if (s1_op == OP_MUL) begin
            p0i = ext_p(m_ii) - ext_p(m_qq);
            p0q = ext_p(m_iq) + ext_p(m_qi);
            p1i = ext_p(m_ii) + ext_p(m_qq);
            p1q = ext_p(m_qi) - ext_p(m_iq);
        end else if (s1_op == OP_PASS) begin
            p0i = ext_w(ai);
            p0q = ext_w(aq);
            p1i = ext_w(bi);
            p1q = ext_w(bq);
        end
    end

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sop       <= 1'b1;
            mode_q    <= 2'd0;
            err_tlast <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_last   <= 1'b0;
            s1_op     <= OP_ADD;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_mul    <= 1'b0;
            s2_p0i    <= '0;
            s2_p0q    <= '0;
            s2_p1i    <= '0;
            s2_p1q    <= '0;
            s3_valid  <= 1'b0;
            o0_tdata  <= '0;
            o1_tdata  <= '0;
            o0_tlast  <= 1'b0;
            o1_tlast  <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            if (accept) begin
                sop <= i0_tlast;
                if (sop)
                    mode_q <= mode;
                if (i0_tlast != i1_tlast)
                    err_tlast <= 1'b1;
            end
            if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a    <= i0_tdata;
                    s1_b    <= i1_tdata;
                    s1_last <= i0_tlast;
                    s1_op   <= (beat_mode == 2'd3) ? OP_ADD : beat_mode;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_last <= s1_last;
                    s2_mul  <= (s1_op == OP_MUL);
                    s2_p0i  <= p0i;
                    s2_p0q  <= p0q;
                    s2_p1i  <= p1i;
                    s2_p1q  <= p1q;
                end
            end
            if (s3_load) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    o0_tdata <= {finish_val(s2_p0i, s2_mul), finish_val(s2_p0q, s2_mul)};
                    o1_tdata <= {finish_val(s2_p1i, s2_mul), finish_val(s2_p1q, s2_mul)};
                    o0_tlast <= s2_last;
                    o1_tlast <= s2_last;
                end
            end
            // Per-port completion flags let each output finish its beat independently.
            if (retire) begin
                done0 <= 1'b0;
                done1 <= 1'b0;
            end else begin
                done0 <= done0 | ok0;
                done1 <= done1 | ok1;
            end
        end
    end
endmodule

// File: tb/tb_cmplx_alu2_pipe.sv
// tb/tb_cmplx_alu2_pipe.sv - self-checking bench for cmplx_alu2_pipe against a behavioural model
module tb_cmplx_alu2_pipe;
    localparam int W  = 16;
    localparam int SH = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [1:0]    mode;
    logic [2*W-1:0] i0_tdata, i1_tdata, o0_tdata, o1_tdata;
    logic          i0_tlast, i0_tvalid, i0_tready;
    logic          i1_tlast, i1_tvalid, i1_tready;
    logic          o0_tlast, o0_tvalid, o0_tready;
    logic          o1_tlast, o1_tvalid, o1_tready;
    logic          err_tlast;

    cmplx_alu2_pipe #(.WIDTH(W), .SHIFT(SH)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
        .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
        .o0_tdata(o0_tdata), .o0_tlast(o0_tlast), .o0_tvalid(o0_tvalid), .o0_tready(o0_tready),
        .o1_tdata(o1_tdata), .o1_tlast(o1_tlast), .o1_tvalid(o1_tvalid), .o1_tready(o1_tready),
        .err_tlast(err_tlast)
    );

    typedef struct {
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        logic           l0;
        logic           l1;
        logic [1:0]     m;
    } beat_t;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    beat_t src_q[$];
    logic [2*W:0] exp0_q[$], exp1_q[$];
    int lat0_q[$], lat1_q[$];
    logic m_sop = 1'b1;
    logic [1:0] m_mode = 2'd0;
    logic m_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat_m(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rnd_m(input longint v);
        return (v + (longint'(1) <<< (SH-1))) >>> SH;
    endfunction

    function automatic logic [2*W-1:0] pk(input longint i, input longint q);
        logic [W-1:0] ri, rq;
        ri = i[W-1:0];
        rq = q[W-1:0];
        return {ri, rq};
    endfunction

    task automatic compute(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [1:0] op,
                           output logic [2*W-1:0] o0, output logic [2*W-1:0] o1);
        longint ai, aq, bi, bq;
        ai = $signed(a[2*W-1:W]);
        aq = $signed(a[W-1:0]);
        bi = $signed(b[2*W-1:W]);
        bq = $signed(b[W-1:0]);
        case (op)
            2'd1: begin
                o0 = pk(sat_m(rnd_m(ai*bi - aq*bq)), sat_m(rnd_m(ai*bq + aq*bi)));
                o1 = pk(sat_m(rnd_m(ai*bi + aq*bq)), sat_m(rnd_m(aq*bi - ai*bq)));
            end
            2'd2: begin
                o0 = a;
                o1 = b;
            end
            default: begin
                o0 = pk(sat_m(ai + bi), sat_m(aq + bq));
                o1 = pk(sat_m(ai - bi), sat_m(aq - bq));
            end
        endcase
    endtask

    task automatic model_accept(input beat_t e);
        logic [2*W-1:0] o0, o1;
        if (m_sop) m_mode = e.m;
        compute(e.a, e.b, m_mode, o0, o1);
        exp0_q.push_back({e.l0, o0});
        exp1_q.push_back({e.l0, o1});
        lat0_q.push_back(cyc);
        lat1_q.push_back(cyc);
        m_sop = e.l0;
        if (e.l0 != e.l1) m_err = 1'b1;
    endtask

    task automatic run(input int max_cyc, input int gap_pct, input bit rnd0, input bit rnd1, input bit chk_lat);
        int t;
        int l;
        beat_t e;
        logic [2*W:0] x;
        t = 0;
        while ((src_q.size() > 0 || exp0_q.size() > 0 || exp1_q.size() > 0) && t < max_cyc) begin
            if (src_q.size() > 0) begin
                e = src_q[0];
                i0_tdata = e.a; i1_tdata = e.b;
                i0_tlast = e.l0; i1_tlast = e.l1;
                mode = e.m;
                i0_tvalid = 1'b1;
                i1_tvalid = ($urandom_range(99) >= gap_pct);
            end else begin
                i0_tvalid = 1'b0;
                i1_tvalid = 1'b0;
            end
            o0_tready = rnd0 ? 1'($urandom_range(1)) : 1'b1;
            o1_tready = rnd1 ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            check("err_tlast", 64'(err_tlast), 64'(m_err));
            if (i0_tvalid && !i1_tvalid) check("gap_stall", 64'(i0_tready), 64'd0);
            if (i0_tready) model_accept(src_q.pop_front());
            if (o0_tvalid && o0_tready) begin
                if (exp0_q.size() == 0) check("o0_extra_beat", 64'd1, 64'd0);
                else begin
                    x = exp0_q.pop_front();
                    l = lat0_q.pop_front();
                    check("o0_beat", 64'({o0_tlast, o0_tdata}), 64'(x));
                    if (chk_lat) check("o0_latency", 64'(cyc - l), 64'd3);
                end
            end
            if (o1_tvalid && o1_tready) begin
                if (exp1_q.size() == 0) check("o1_extra_beat", 64'd1, 64'd0);
                else begin
                    x = exp1_q.pop_front();
                    l = lat1_q.pop_front();
                    check("o1_beat", 64'({o1_tlast, o1_tdata}), 64'(x));
                    if (chk_lat) check("o1_latency", 64'(cyc - l), 64'd3);
                end
            end
            @(posedge clk); #1;
            t++;
        end
        i0_tvalid = 1'b0;
        i1_tvalid = 1'b0;
        check("run_drained", 64'(src_q.size() + exp0_q.size() + exp1_q.size()), 64'd0);
    endtask

    task automatic single(input string tag, input logic [1:0] md, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                          input logic [2*W-1:0] e0, input logic [2*W-1:0] e1);
        int lat;
        lat = 0;
        mode = md; i0_tdata = a; i1_tdata = b;
        i0_tlast = 1'b1; i1_tlast = 1'b1;
        i0_tvalid = 1'b1; i1_tvalid = 1'b1;
        o0_tready = 1'b1; o1_tready = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, 64'(i0_tready), 64'd1);
        @(posedge clk); #1;
        i0_tvalid = 1'b0; i1_tvalid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o0_tvalid && lat < 8);
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_o0"}, 64'(o0_tdata), 64'(e0));
        check({tag, "_o1_valid"}, 64'(o1_tvalid), 64'd1);
        check({tag, "_o1"}, 64'(o1_tdata), 64'(e1));
        check({tag, "_tlast"}, 64'({o0_tlast, o1_tlast}), 64'd3);
        @(posedge clk); #1;
    endtask

    task automatic push_beat(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic l0, input logic l1, input logic [1:0] m);
        beat_t e;
        e.a = a; e.b = b; e.l0 = l0; e.l1 = l1; e.m = m;
        src_q.push_back(e);
    endtask

    initial begin
        logic [2*W-1:0] ra, rb;
        logic lst;
        reset_n = 1'b0;
        mode = 2'd0;
        i0_tdata = 32'h1111_2222; i1_tdata = 32'h3333_4444;
        i0_tlast = 1'b1; i1_tlast = 1'b0;
        i0_tvalid = 1'b1; i1_tvalid = 1'b1;
        o0_tready = 1'b1; o1_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_i0_tready", 64'(i0_tready), 64'd0);
        check("rst_i1_tready", 64'(i1_tready), 64'd0);
        check("rst_tvalid", 64'({o0_tvalid, o1_tvalid}), 64'd0);
        check("rst_tdata", 64'({o0_tdata, o1_tdata}), 64'd0);
        check("rst_tlast", 64'({o0_tlast, o1_tlast}), 64'd0);
        check("rst_err", 64'(err_tlast), 64'd0);
        i0_tvalid = 1'b0; i1_tvalid = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        single("add_sat", 2'd0, 32'h7000_0001, 32'h2000_0002, 32'h7FFF_0003, 32'h5000_FFFF);
        single("add_negsat", 2'd0, 32'h8000_8000, 32'hFFFF_0001, 32'h8000_8001, 32'h8001_8000);
        single("mode3_add", 2'd3, 32'h0010_FFF0, 32'h0001_0001, 32'h0011_FFF1, 32'h000F_FFEF);
        single("mul_real", 2'd1, 32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 32'h2000_0000);
        single("mul_imag", 2'd1, 32'h0000_4000, 32'h4000_0000, 32'h0000_2000, 32'h0000_2000);
        single("mul_sat", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h7FFF_0000);
        single("mul_negsat", 2'd1, 32'h8000_0000, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_8000);
        single("pass", 2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);

        // Mode switches after the first beat; the whole packet stays add/sub.
        push_beat(32'h0100_0200, 32'h0010_0020, 1'b0, 1'b0, 2'd0);
        push_beat(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 2'd1);
        push_beat(32'h7000_1000, 32'h2000_F000, 1'b0, 1'b0, 2'd1);
        push_beat(32'h0003_0004, 32'h0001_0001, 1'b1, 1'b1, 2'd1);
        push_beat(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 2'd1);
        push_beat(32'h0000_4000, 32'h4000_0000, 1'b1, 1'b1, 2'd0);
        run(200, 0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) ra = 32'h8000_8000;
            if ($urandom_range(7) == 0) rb = 32'h7FFF_8000;
            lst = ($urandom_range(7) == 0) || (k == 999);
            push_beat(ra, rb, lst, lst, 2'($urandom_range(3)));
        end
        run(20000, 10, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 200; k++) begin
            lst = ($urandom_range(5) == 0) || (k == 199);
            push_beat($urandom, $urandom, lst, lst, 2'($urandom_range(3)));
        end
        run(5000, 20, 1'b1, 1'b1, 1'b0);

        push_beat(32'h0001_0001, 32'h0001_0001, 1'b0, 1'b0, 2'd0);
        push_beat(32'h0002_0002, 32'h0001_0001, 1'b0, 1'b1, 2'd0);
        push_beat(32'h0003_0003, 32'h0001_0001, 1'b0, 1'b0, 2'd0);
        push_beat(32'h0004_0004, 32'h0001_0001, 1'b1, 1'b1, 2'd0);
        run(200, 0, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 64'(err_tlast), 64'd1);

        // Fill the pipeline mid-packet, then reset between clock edges.
        mode = 2'd0;
        i0_tdata = 32'h0101_0101; i1_tdata = 32'h0202_0202;
        i0_tlast = 1'b0; i1_tlast = 1'b0;
        i0_tvalid = 1'b1; i1_tvalid = 1'b1;
        o0_tready = 1'b0; o1_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("prereset_o0_valid", 64'(o0_tvalid), 64'd1);
        check("prereset_stall", 64'(i0_tready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'({o0_tvalid, o1_tvalid}), 64'd0);
        check("async_rst_ready", 64'({i0_tready, i1_tready}), 64'd0);
        check("async_rst_err", 64'(err_tlast), 64'd0);
        check("async_rst_tdata", 64'({o0_tdata, o1_tdata}), 64'd0);
        i0_tvalid = 1'b0; i1_tvalid = 1'b0;
        src_q.delete(); exp0_q.delete(); exp1_q.delete(); lat0_q.delete(); lat1_q.delete();
        m_sop = 1'b1; m_mode = 2'd0; m_err = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_beat(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 2'd1);
        push_beat(32'h2000_2000, 32'h4000_C000, 1'b1, 1'b1, 2'd0);
        run(100, 0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
